cdc_handshake_src: RTL



---
 rtl/cdc_handshake_src.sv | 115 +++++++++++
 1 files changed

// File: rtl/cdc_handshake_src.sv
// Source-domain end of a toggle req/ack CDC handshake: holds a word on xfer_data, toggles xfer_req after a setup delay.
// Optional ack-timeout flag enabled by defining CDC_HANDSHAKE_TIMEOUT_EN.
module cdc_handshake_src #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  xfer_req,
  input  logic                  xfer_ack,
  output logic                  done,
  output logic                  timeout
);

  localparam int SCW = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT} state_t;

  state_t                         state, state_nxt;
  logic [SCW-1:0]                 setup_cnt;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync;
  logic                           ack_s;
  logic                           acked;
  logic                           accept;
  logic                           launch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign acked = (ack_s == xfer_req);

  // done is decoded straight from the synchronized ack so completion is seen SYNC_STAGES edges after the toggle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    launch    = 1'b0;
    done      = 1'b0;
    in_ready  = (state == S_IDLE);
    case (state)
      S_IDLE:  if (in_valid) begin
                 accept    = 1'b1;
                 state_nxt = S_SETUP;
               end
      S_SETUP: if (setup_cnt == '0) begin
                 launch    = 1'b1;
                 state_nxt = S_WAIT;
               end
      S_WAIT:  if (acked) begin
                 done      = 1'b1;
                 state_nxt = S_IDLE;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_data <= '0;
      xfer_req  <= 1'b0;
      setup_cnt <= '0;
    end else begin
      if (accept) begin
        xfer_data <= in_data;
        setup_cnt <= SCW'(SETUP_CYCLES - 1);
      end else if (state == S_SETUP && !launch) begin
        setup_cnt <= setup_cnt - SCW'(1);
      end
      if (launch) xfer_req <= ~xfer_req;
    end
  end

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (launch) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && wait_cnt != TCW'(TIMEOUT_CYCLES)) begin
      wait_cnt <= wait_cnt + TCW'(1);
      if (wait_cnt == TCW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

`ifndef SYNTHESIS
  a_ack_quiet: assert property (@(posedge clk) disable iff (!reset_n)
    (state != S_WAIT) |-> acked);
  a_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (state != S_IDLE) |=> $stable(xfer_data));
  a_done_single: assert property (@(posedge clk) disable iff (!reset_n)
    done |=> !done);
`endif

endmodule
